// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and width helpers for the UART receive control unit
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Bit timer width; it must hold CLKS_PER_BIT - 1.
    function automatic int timer_width(input int clks_per_bit);
        return (clks_per_bit > 2) ? $clog2(clks_per_bit) : 1;
    endfunction

    // Bit counter width; it must hold DATA_BITS - 1 with headroom for the increment.
    function automatic int bitcnt_width(input int data_bits);
        return $clog2(data_bits + 1);
    endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// rtl/uart_rx_bit_timer.sv - down-counting bit timer producing the mid-bit sample tick
module uart_rx_bit_timer
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int TW           = 4
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          i_load,
    input  logic [TW-1:0] i_load_val,
    input  logic          i_en,
    output logic          o_sample_tick
);

    localparam logic [TW-1:0] RELOAD = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] r_cnt;

    // The tick is suppressed in the load cycle so a stale zero never fires a sample.
    assign o_sample_tick = i_en && !i_load && (r_cnt == '0);

    // Load on start, otherwise count down and wrap to a full bit period after each sample.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en) begin
            r_cnt <= (r_cnt == '0) ? RELOAD : r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive FSM, shift register and status flags; optional parity via UART_RX_PARITY_EN
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start_bit_detected,
    input  logic                 rx_line,
    input  logic                 data_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 framing_error,
    output logic                 overrun_error,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_error,
`endif
    output logic                 rx_busy
);

    localparam int TW = timer_width(CLKS_PER_BIT);
    localparam int BW = bitcnt_width(DATA_BITS);
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    rx_state_t            r_state;
    rx_state_t            w_state_nxt;
    logic                 w_timer_load;
    logic                 w_timer_en;
    logic                 w_sample_tick;
    logic                 w_last_bit;
    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_load_pend;
    logic                 r_stop_bit;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_data_ready;
    logic                 r_framing_error;
    logic                 r_overrun_error;
    logic                 r_rx_busy;
`ifdef UART_RX_PARITY_EN
    logic                 r_parity_pend;
    logic                 r_parity_error;

    assign parity_error = r_parity_error;
`endif

    assign rx_data       = r_rx_data;
    assign data_ready    = r_data_ready;
    assign framing_error = r_framing_error;
    assign overrun_error = r_overrun_error;
    assign rx_busy       = r_rx_busy;

    assign w_timer_load = (r_state == IDLE) && start_bit_detected;
    assign w_timer_en   = (r_state != IDLE);
    assign w_last_bit   = (r_bit_cnt == LAST_BIT);

    uart_rx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .TW           (TW)
    ) u_bit_timer (
        .clk           (clk),
        .n_rst         (n_rst),
        .i_load        (w_timer_load),
        .i_load_val    (HALF_LOAD),
        .i_en          (w_timer_en),
        .o_sample_tick (w_sample_tick)
    );

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; every transition past IDLE happens only on a sample tick.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:   if (start_bit_detected) w_state_nxt = START;
            START:  if (w_sample_tick) w_state_nxt = rx_line ? IDLE : DATA;
            DATA: begin
                if (w_sample_tick && w_last_bit) begin
`ifdef UART_RX_PARITY_EN
                    w_state_nxt = PARITY;
`else
                    w_state_nxt = STOP;
`endif
                end
            end
            PARITY: if (w_sample_tick) w_state_nxt = STOP;
            STOP:   if (w_sample_tick) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Frame datapath: bit count, LSB-first shift, stop/parity capture, then a one-cycle-later load.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_bit_cnt       <= '0;
            r_shift         <= '0;
            r_load_pend     <= 1'b0;
            r_stop_bit      <= 1'b0;
            r_rx_data       <= '0;
            r_data_ready    <= 1'b0;
            r_framing_error <= 1'b0;
            r_overrun_error <= 1'b0;
            r_rx_busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_pend   <= 1'b0;
            r_parity_error  <= 1'b0;
`endif
        end else begin
            r_rx_busy   <= (w_state_nxt != IDLE);
            r_load_pend <= 1'b0;

            case (r_state)
                START: if (w_sample_tick && !rx_line) r_bit_cnt <= '0;
                DATA: begin
                    if (w_sample_tick) begin
                        r_shift   <= {rx_line, r_shift[DATA_BITS-1:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (w_sample_tick) begin
                        r_parity_pend <= rx_line ^ (^r_shift) ^ (PARITY_ODD != 0);
                    end
                end
`endif
                STOP: begin
                    if (w_sample_tick) begin
                        r_load_pend <= 1'b1;
                        r_stop_bit  <= rx_line;
                    end
                end
                default: ;
            endcase

            // A load outranks a simultaneous read: the word stays pending, and the read
            // only prevents (and clears) the overrun.
            if (r_load_pend) begin
                r_rx_data       <= r_shift;
                r_framing_error <= ~r_stop_bit;
                r_data_ready    <= 1'b1;
                if (r_data_ready && !data_read) begin
                    r_overrun_error <= 1'b1;
                end else if (data_read) begin
                    r_overrun_error <= 1'b0;
                end
`ifdef UART_RX_PARITY_EN
                r_parity_error  <= r_parity_pend;
`endif
            end else if (data_read) begin
                r_data_ready    <= 1'b0;
                r_overrun_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard bench for uart_rx_ctrl with directed frames
module tb_uart_rx_ctrl;

    logic       clk;
    logic       n_rst;
    logic       start_bit_detected;
    logic       rx_line;
    logic       data_read;
    logic [7:0] rx_data;
    logic       data_ready;
    logic       framing_error;
    logic       overrun_error;
    logic       rx_busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_error;
`endif

    uart_rx_ctrl #(
        .CLKS_PER_BIT (16),
        .DATA_BITS    (8),
        .PARITY_ODD   (0)
    ) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .start_bit_detected (start_bit_detected),
        .rx_line            (rx_line),
        .data_read          (data_read),
        .rx_data            (rx_data),
        .data_ready         (data_ready),
        .framing_error      (framing_error),
        .overrun_error      (overrun_error),
`ifdef UART_RX_PARITY_EN
        .parity_error       (parity_error),
`endif
        .rx_busy            (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       dr;
        logic       fe;
        logic       ov;
        logic       busy;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic expect_at(input int c, input logic [7:0] d, input logic dr, input logic fe,
                             input logic ov, input logic busy, input string name);
        exp_t x;
        x.cyc = c; x.data = d; x.dr = dr; x.fe = fe; x.ov = ov; x.busy = busy; x.name = name;
        sb.push_back(x);
    endtask

    // Monitor: compares the DUT outputs against each expectation in the cycle it is due.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_chk++;
            if (e.cyc < cyc) begin
                $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
            end else if ({rx_data, data_ready, framing_error, overrun_error, rx_busy} !==
                         {e.data, e.dr, e.fe, e.ov, e.busy}) begin
                $display("FAIL %s @%0d: got data=%02h dr=%0b fe=%0b ov=%0b busy=%0b, want data=%02h dr=%0b fe=%0b ov=%0b busy=%0b",
                         e.name, cyc, rx_data, data_ready, framing_error, overrun_error, rx_busy,
                         e.data, e.dr, e.fe, e.ov, e.busy);
            end else begin
                n_pass++;
            end
        end
    end

    // Drives one frame; window w covers the edge t+w where t is the edge that sees the pulse.
    task automatic drive_frame(input logic [7:0] d, input logic stop_v, input bit rd_at_load,
                               input int glitch_len, input int abort_w);
        int  last_w;
        bit  aborted;
        last_w  = (glitch_len > 0) ? 31 : 159;
        aborted = 0;
        for (int w = 0; w <= last_w && !aborted; w++) begin
            start_bit_detected = (w == 0);
            if (glitch_len > 0)  rx_line = (w >= glitch_len);
            else if (w < 16)     rx_line = 1'b0;
            else if (w < 144)    rx_line = d[(w - 16) / 16];
            else                 rx_line = stop_v;
            data_read = rd_at_load && (w == 153);
            if (abort_w > 0 && w == abort_w) begin
                n_rst = 1'b0;
                aborted = 1;
            end
            @(negedge clk);
        end
        n_rst              = 1'b1;
        start_bit_detected = 1'b0;
        rx_line            = 1'b1;
        data_read          = 1'b0;
    endtask

    task automatic frame_ok(input logic [7:0] d, input logic stop_v, input bit rd_at_load,
                            input logic dr, input logic fe, input logic ov, input string name);
        int t;
        t = cyc + 1;
        expect_at(t + 153, d, dr, fe, ov, 1'b0, name);
        drive_frame(d, stop_v, rd_at_load, 0, 0);
    endtask

    task automatic read_word(input logic [7:0] d, input logic fe, input string name);
        data_read = 1'b1;
        expect_at(cyc + 1, d, 1'b0, fe, 1'b0, 1'b0, name);
        @(negedge clk);
        data_read = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t;
        n_rst              = 1'b0;
        start_bit_detected = 1'b0;
        rx_line            = 1'b1;
        data_read          = 1'b0;
        repeat (3) @(negedge clk);
        expect_at(cyc + 1, 8'h00, 0, 0, 0, 0, "reset");
        n_rst = 1'b1;
        repeat (3) @(negedge clk);

        // 1: good frame, exact latency of data_ready
        t = cyc + 1;
        expect_at(t + 5,   8'h00, 0, 0, 0, 1, "t1_busy");
        expect_at(t + 152, 8'h00, 0, 0, 0, 0, "t1_before_load");
        expect_at(t + 153, 8'hA5, 1, 0, 0, 0, "t1_load");
        drive_frame(8'hA5, 1'b1, 0, 0, 0);

        // 2: start glitch rejected, flags untouched
        t = cyc + 1;
        expect_at(t + 5, 8'hA5, 1, 0, 0, 1, "t2_busy");
        expect_at(t + 9, 8'hA5, 1, 0, 0, 0, "t2_glitch_idle");
        drive_frame(8'h00, 1'b1, 0, 4, 0);
        read_word(8'hA5, 1'b0, "t2_read");

        // 3: framing error, held across read, cleared by next good frame
        frame_ok(8'h3C, 1'b0, 0, 1, 1, 0, "t3_framing");
        read_word(8'h3C, 1'b1, "t3_read_holds_fe");
        frame_ok(8'h81, 1'b1, 0, 1, 0, 0, "t3_fe_cleared");
        read_word(8'h81, 1'b0, "t3_read");

        // 4: overrun
        frame_ok(8'h11, 1'b1, 0, 1, 0, 0, "t4_first");
        frame_ok(8'h22, 1'b1, 0, 1, 0, 1, "t4_overrun");
        read_word(8'h22, 1'b0, "t4_read_clears");

        // 5: read coincides with load
        frame_ok(8'h44, 1'b1, 0, 1, 0, 0, "t5_first");
        frame_ok(8'h99, 1'b1, 1, 1, 0, 0, "t5_read_at_load");
        read_word(8'h99, 1'b0, "t5_read");

        // 6: reset mid-frame at bit 4, then a clean frame
        t = cyc + 1;
        expect_at(t + 88, 8'h00, 0, 0, 0, 0, "t6_reset");
        drive_frame(8'h5A, 1'b1, 0, 0, 88);
        repeat (3) @(negedge clk);
        frame_ok(8'h5A, 1'b1, 0, 1, 0, 0, "t6_after_reset");

        repeat (5) @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_chk++;
            $display("FAIL %s: expectation for cycle %0d never checked", e.name, e.cyc);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
